// File: rtl/serial_pattern_pkg.sv
// Shared types and default parameters for the serial pattern detector.
package serial_pattern_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_e;

  localparam int                W_DEF       = 4;
  localparam logic [W_DEF-1:0]  PATTERN_DEF = 4'b1011;
  localparam int                CNT_W_DEF   = 8;

endpackage

// File: rtl/pattern_shift.sv
// History shift register plus fill counter; fill saturates at W and can be
// zeroed on a non-overlapping match while the bit still shifts in.
module pattern_shift
  import serial_pattern_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int FW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          valid,
  input  logic          x,
  input  logic          clear,
  input  logic          clr_fill,
  output logic [W-1:0]  hist,
  output logic [FW-1:0] fill
);

  logic [W-1:0]  hist_q;
  logic [FW-1:0] fill_q;

  // Shift accepted bits in; clear wins over a simultaneous valid bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clear) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (valid) begin
      hist_q <= {hist_q[W-2:0], x};
      if (clr_fill)
        fill_q <= '0;
      else if (fill_q != FW'(W))
        fill_q <= fill_q + FW'(1);
    end
  end

  assign hist = hist_q;
  assign fill = fill_q;

endmodule

// File: rtl/serial_pattern_fsm.sv
// Serial pattern detector: FSM, match compare, registered z pulse and a
// saturating match counter around the pattern_shift history.
module serial_pattern_fsm
  import serial_pattern_pkg::*;
#(
  parameter int           W       = W_DEF,
  parameter logic [W-1:0] PATTERN = PATTERN_DEF,
  parameter int           CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             valid,
  input  logic             x,
  input  logic             overlap,
  input  logic             clear,
  output logic             z,
  output logic [CNT_W-1:0] count
);

  localparam int FW = $clog2(W + 1);

  state_e           state_q, state_d;
  logic             z_q, z_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     hist;
  logic [FW-1:0]    fill;
  logic             match;
  logic             clr_fill;
  logic             full_next;
  logic             unused_hist_msb;

  // The oldest history bit falls out on the next shift and is never compared.
  assign unused_hist_msb = hist[W-1];

  pattern_shift #(.W(W), .FW(FW)) u_shift (
    .clk      (clk),
    .resetn   (resetn),
    .valid    (valid),
    .x        (x),
    .clear    (clear),
    .clr_fill (clr_fill),
    .hist     (hist),
    .fill     (fill)
  );

  // State, pulse and counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= EMPTY;
      z_q     <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      count_q <= count_d;
    end
  end

  // Next-state, match detection and counter update on accepted bits only.
  always_comb begin
    state_d   = state_q;
    match     = 1'b0;
    z_d       = 1'b0;
    count_d   = count_q;
    full_next = (state_q == ARMED) || (state_q == FILL && fill == FW'(W - 1));
    if (clear) begin
      state_d = EMPTY;
      count_d = '0;
    end else if (valid) begin
      match = full_next && ({hist[W-2:0], x} == PATTERN);
      case (state_q)
        EMPTY:   state_d = FILL;
        FILL:    state_d = full_next ? ARMED : FILL;
        ARMED:   state_d = ARMED;
        default: state_d = EMPTY;
      endcase
      if (match && !overlap) state_d = EMPTY;
      z_d = match;
      if (match && count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
    end
  end

  assign clr_fill = match & ~overlap;
  assign z        = z_q;
  assign count    = count_q;

endmodule

// File: doc/serial_pattern_fsm.md
SERIAL_PATTERN_FSM -- requirements
Module: serial_pattern_fsm

Interface
REQ-001 Parameter W, default 4: pattern length in bits; legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1011, width W: target sequence; PATTERN[W-1] is matched first.
REQ-003 Parameter CNT_W, default 8: match-counter width; legal range 1..16.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 resetn  input  1: asynchronous, active-low reset.
REQ-006 valid  input  1: x is accepted this cycle when high.
REQ-007 x  input  1: serial data bit.
REQ-008 overlap  input  1: 1 = overlapping detection, 0 = non-overlapping.
REQ-009 clear  input  1: synchronous soft clear of all state.
REQ-010 z  output  1: registered one-cycle match pulse.
REQ-011 count  output  CNT_W: saturating number of matches since reset or clear.

Function
REQ-012 The block SHALL hold a W-bit history hist and a fill counter fill (0..W); accepting a bit sets hist <= {hist[W-2:0], x}.
REQ-013 The FSM SHALL have three states: EMPTY (fill=0), FILL (0<fill<W) and ARMED (fill=W).
REQ-014 State transitions SHALL occur only on accepted bits:
- EMPTY->FILL.
- FILL->FILL until fill reaches W, then ->ARMED.
- ARMED stays ARMED, except a non-overlap match -> EMPTY.
REQ-015 A match SHALL occur on an accepted bit when fill after that bit equals W and {hist[W-2:0], x} == PATTERN.
REQ-016 z SHALL be 1 in exactly the cycle after the cycle in which a matching bit is accepted, and 0 otherwise.
REQ-017 With overlap=0, a match SHALL set fill to 0, so the bits of one match are never reused.
REQ-018 With overlap=1, fill SHALL stay at W after a match.
REQ-019 overlap SHALL be sampled on the accepted bit that produces a match; changing it never alters fill by itself.
REQ-020 When valid=0, hist, fill, state and count SHALL hold, and z SHALL be 0 in the next cycle.
REQ-021 count SHALL increment by 1 per match and saturate at 2^CNT_W-1 without wrapping.
REQ-022 clear=1 SHALL set hist, fill, count and z to 0 and the state to EMPTY at the next edge.
REQ-023 When clear and valid are both high, clear SHALL win and the bit SHALL be discarded.

Reset
REQ-024 resetn=0 SHALL immediately force state=EMPTY, fill=0, hist=0, z=0 and count=0, regardless of clk.
REQ-025 A reset asserted mid-pattern SHALL discard partial progress; detection restarts from the first accepted bit after release.
REQ-026 Reset release SHALL be synchronised externally; the block adds no synchroniser.

Structure
REQ-027 A shared package serial_pattern_pkg SHALL hold:
- the state enum (EMPTY, FILL, ARMED);
- the default parameter constants W_DEF, PATTERN_DEF and CNT_W_DEF.
REQ-028 The history shift register and fill counter SHALL be one sub-module, pattern_shift, with an interface of valid, x, clear, clr_fill, hist and fill.
REQ-029 The FSM, match compare, z register and counter SHALL reside in the top level.

Verification
REQ-030 Stream 1,0,1,1,0,1,1 (W=4, PATTERN=1011, overlap=1, valid continuous) -> z pulses after bits 4 and 7; count=2.
REQ-031 Same stream with overlap=0 -> z pulses after bit 4 only; count=1; fill=3 at end.
REQ-032 Stream 1,0,1,1 with valid=0 gaps of 3 cycles between bits -> single z pulse one cycle after the 4th bit is accepted; no pulse during gaps.
REQ-033 CNT_W=2, overlap=1, stream 1,0,1,1 followed by 0,1,1 repeated 5 times -> count reaches 3 and holds; z pulses 6 times.
REQ-034 resetn pulsed low after bits 1,0,1 (asynchronously, mid-cycle), then stream 1 -> no z; count=0; outputs are 0 during reset.
REQ-035 clear=1 with valid=1 and x=1 after bits 1,0,1 -> next stream 1,0,1,1 gives exactly one z, after its 4th bit.
